// File: rtl/ddr3_wr_burst_seq.sv
// Write-burst sequencer for one DDR3 byte lane: feeds the 4:1 DQ/DM/DQS output
// serializers with write-latency delay, DQS preamble, BL8 data beats and postamble.
module ddr3_wr_burst_seq #(
    parameter int DQ_WIDTH = 8,
    parameter int NB_BITS  = 4
) (
    input  logic                    clk_div,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [3:0]              wlat,
    input  logic [NB_BITS-1:0]      nbursts,
    input  logic [4*DQ_WIDTH-1:0]   data_in,
    input  logic [3:0]              mask_in,
    output logic                    data_rd,
    output logic [4*DQ_WIDTH-1:0]   dq_din,
    output logic [4*DQ_WIDTH-1:0]   dq_tin,
    output logic [3:0]              dm_din,
    output logic [3:0]              dm_tin,
    output logic [3:0]              dqs_din,
    output logic [3:0]              dqs_tin,
    output logic                    busy,
    output logic                    done,
    output logic                    start_err
);

    localparam int CW = NB_BITS + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRE,
        S_DATA,
        S_POST
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
    logic                    accept;

    logic                    data_rd_q, data_rd_d;
    logic [4*DQ_WIDTH-1:0]   dq_din_q, dq_din_d;
    logic [4*DQ_WIDTH-1:0]   dq_tin_q, dq_tin_d;
    logic [3:0]              dm_din_q, dm_din_d;
    logic [3:0]              dm_tin_q, dm_tin_d;
    logic [3:0]              dqs_din_q, dqs_din_d;
    logic [3:0]              dqs_tin_q, dqs_tin_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    start_err_q, start_err_d;

    // The state runs one cycle ahead of the registered outputs, so busy_q still
    // covers the postamble cycle after state_q has already returned to IDLE.
    assign accept = start && (state_q == S_IDLE) && !busy_q;

    // NOTE: every signal assigned in always_comb gets a default first; a missed
    // branch would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wait_cnt_d = wlat - 4'd1;
                    beat_cnt_d = {nbursts, 1'b1};  // beats-1 = 2*(nbursts+1)-1
                    state_d    = (wlat == 4'd0) ? S_PRE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) state_d = S_PRE;
                else                    wait_cnt_d = wait_cnt_q - 4'd1;
            end
            S_PRE:  state_d = S_DATA;
            S_DATA: begin
                if (beat_cnt_q == '0) state_d = S_POST;
                else                  beat_cnt_d = beat_cnt_q - CW'(1);
            end
            S_POST: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_rd_d   = 1'b0;
        dq_din_d    = data_rd_q ? data_in : dq_din_q;
        dm_din_d    = data_rd_q ? mask_in : dm_din_q;
        dq_tin_d    = '1;
        dm_tin_d    = 4'hF;
        dqs_din_d   = 4'b0000;
        dqs_tin_d   = 4'hF;
        busy_d      = (state_q != S_IDLE);
        done_d      = 1'b0;
        start_err_d = start && !accept;
        case (state_q)
            S_PRE: begin
                dqs_tin_d = 4'b0011;
                data_rd_d = 1'b1;
            end
            S_DATA: begin
                dq_tin_d  = '0;
                dm_tin_d  = 4'h0;
                dqs_din_d = 4'b0101;
                dqs_tin_d = 4'h0;
                data_rd_d = (beat_cnt_q != '0);
            end
            S_POST: begin
                dqs_tin_d = 4'b1110;
                done_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            data_rd_q   <= 1'b0;
            dq_din_q    <= '0;
            dq_tin_q    <= '1;
            dm_din_q    <= '0;
            dm_tin_q    <= 4'hF;
            dqs_din_q   <= '0;
            dqs_tin_q   <= 4'hF;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            data_rd_q   <= data_rd_d;
            dq_din_q    <= dq_din_d;
            dq_tin_q    <= dq_tin_d;
            dm_din_q    <= dm_din_d;
            dm_tin_q    <= dm_tin_d;
            dqs_din_q   <= dqs_din_d;
            dqs_tin_q   <= dqs_tin_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_err_q <= start_err_d;
        end
    end

    assign data_rd   = data_rd_q;
    assign dq_din    = dq_din_q;
    assign dq_tin    = dq_tin_q;
    assign dm_din    = dm_din_q;
    assign dm_tin    = dm_tin_q;
    assign dqs_din   = dqs_din_q;
    assign dqs_tin   = dqs_tin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign start_err = start_err_q;

endmodule
